input_buf_resp: RTL

INPUT_BUF_RESP -- requirements
Module: input_buf_resp

---
 rtl/input_buf_resp.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/input_buf_resp.sv
// input_buf_resp
//   Banked pixel input buffer. A producer fills POY x NROW x NCOL pixels while
//   the buffer is in FILL; once the last pixel lands the block is handed to the
//   consumer (READY), which issues pipelined reads with a fixed 3-cycle latency
//   until it releases the block.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   wr_en/wr_bank/wr_row/wr_col/wr_data   fill write port
//   wr_ready              high while fill writes are accepted (FILL)
//   blkend                one-cycle pulse when the block is fully loaded
//   blk_release           consumer done with block (READY -> FILL)
//   rpsel                 read mode: 00 RR all banks, 01 BR one bank,
//                         10 RP one pixel, 11 NE no request
//   bank/row/col          read address
//   rdata/rlane/rvalid    read response: lane b in rdata[b*DW +: DW]
//   err                   sticky protocol-error flag
module input_buf_resp #(
  parameter int POY  = 3,
  parameter int DW   = 8,
  parameter int NROW = 4,
  parameter int NCOL = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_bank,
  input  logic [1:0]        wr_row,
  input  logic [27:0]       wr_col,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_ready,
  output logic              blkend,
  input  logic              blk_release,
  input  logic [1:0]        rpsel,
  input  logic [1:0]        bank,
  input  logic [1:0]        row,
  input  logic [27:0]       col,
  output logic [POY*DW-1:0] rdata,
  output logic [POY-1:0]    rlane,
  output logic              rvalid,
  output logic              err
);

  localparam int BW = (POY  > 1) ? $clog2(POY)  : 1;
  localparam int RW = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [15:0] TOTAL = 16'(POY * NROW * NCOL);

  localparam logic [1:0] MODE_RR = 2'b00;
  localparam logic [1:0] MODE_BR = 2'b01;
  localparam logic [1:0] MODE_RP = 2'b10;
  localparam logic [1:0] MODE_NE = 2'b11;

  typedef enum logic {FILL, READY} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        blkend_nxt, err_nxt;

  logic [DW-1:0] mem [POY][NROW][NCOL];

  // ---------------- fill side ----------------
  logic wr_ok, wr_acc;
  assign wr_ok  = (32'(wr_bank) < POY) && (32'(wr_row) < NROW) && (32'(wr_col) < NCOL);
  assign wr_acc = (state == FILL) && wr_en && wr_ok;
  assign wr_ready = (state == FILL);

  // Storage is intentionally not reset; gating on rst_n keeps a write that
  // coincides with reset from landing.
  always_ff @(posedge clk) begin
    if (wr_acc && rst_n)
      mem[wr_bank[BW-1:0]][wr_row[RW-1:0]][wr_col[CW-1:0]] <= wr_data;
  end

  // ---------------- read request decode ----------------
  logic          req, rd_bank_ok, pad, req_ok, req_bad;
  logic [BW-1:0] rb;
  logic [RW-1:0] rr;
  logic [CW-1:0] rc;

  assign req        = (rpsel != MODE_NE);
  assign rd_bank_ok = (32'(bank) < POY);
  assign pad        = !((32'(row) < NROW) && (32'(col) < NCOL));
  assign req_ok     = req && (state == READY) && ((rpsel == MODE_RR) || rd_bank_ok);
  assign req_bad    = req && !req_ok;

  // Out-of-range addresses are steered to entry 0; the padding mux discards
  // the value, so the array is never indexed beyond its bounds.
  assign rb = rd_bank_ok ? bank[BW-1:0] : '0;
  assign rr = pad ? '0 : row[RW-1:0];
  assign rc = pad ? '0 : col[CW-1:0];

  logic [POY*DW-1:0] d0;
  logic [POY-1:0]    l0;

  // Data is captured at the request edge, so writes during a later FILL
  // cannot corrupt responses still in flight.
  always_comb begin
    d0 = '0;
    l0 = '0;
    if (req_ok) begin
      case (rpsel)
        MODE_RR: begin
          l0 = '1;
          for (int b = 0; b < POY; b++)
            if (!pad) d0[b*DW +: DW] = mem[b][rr][rc];
        end
        MODE_BR: begin
          l0[POY-1] = 1'b1;
          if (!pad) d0[(POY-1)*DW +: DW] = mem[rb][rr][rc];
        end
        MODE_RP: begin
          l0[0] = 1'b1;
          if (!pad) d0[DW-1:0] = mem[rb][rr][rc];
        end
        default: ;
      endcase
    end
  end

  // ---------------- control FSM ----------------
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    blkend_nxt = 1'b0;
    err_nxt    = err;
    case (state)
      FILL: begin
        if (wr_acc) begin
          if (cnt == TOTAL - 16'd1) begin
            state_nxt  = READY;
            cnt_nxt    = '0;
            blkend_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      READY: begin
        if (blk_release) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
    if ((wr_en && !wr_ok) || (wr_en && (state == READY)) || req_bad)
      err_nxt = 1'b1;
  end

  // ---------------- registers ----------------
  logic              v1, v2;
  logic [POY*DW-1:0] d1, d2;
  logic [POY-1:0]    l1, l2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FILL;
      cnt    <= '0;
      blkend <= 1'b0;
      err    <= 1'b0;
      v1     <= 1'b0;
      d1     <= '0;
      l1     <= '0;
      v2     <= 1'b0;
      d2     <= '0;
      l2     <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rlane  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      blkend <= blkend_nxt;
      err    <= err_nxt;
      v1     <= req_ok;
      d1     <= d0;
      l1     <= l0;
      v2     <= v1;
      d2     <= d1;
      l2     <= l1;
      rvalid <= v2;
      rdata  <= d2;
      rlane  <= l2;
    end
  end

endmodule
